// File: rtl/gate_alu_arbiter.sv
// Two-requester round-robin arbiter feeding a bitwise gate ALU.
// IDLE grants one requester, EXEC computes the result, RESP holds it until consumed.
module gate_alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       done_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic             grant1;
    logic [WIDTH-1:0] gate_res;
    logic             gate_err;

    // On a tie the requester not named by last_grant wins.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req1_ready = (state_q == IDLE) && grant1;
        req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    end

    always_comb begin
        gate_res = '0;
        gate_err = 1'b0;
        case (op_q)
            3'b000:  gate_res = a_q & b_q;
            3'b001:  gate_res = a_q | b_q;
            3'b010:  gate_res = ~(a_q & b_q);
            3'b011:  gate_res = ~(a_q | b_q);
            3'b100:  gate_res = ~a_q;
            3'b101:  gate_res = a_q ^ b_q;
            3'b110:  gate_res = ~(a_q ^ b_q);
            default: gate_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    op_d    = grant1 ? req1_op : req0_op;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    id_d    = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = gate_res;
                rsp_err_d  = gate_err;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    done_cnt_d   = done_cnt_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gate_alu_arbiter.sv
// Directed plus randomized checks of gate_alu_arbiter against a transaction-level model.
module tb_gate_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0] rsp_data, done_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic       m_last_grant;
    logic [7:0] m_done;
    logic [7:0] obs_data;
    logic       obs_id;

    gate_alu_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {err, data}.
    function automatic logic [8:0] ref_gate(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, ~(a & b)};
            3'd3:    return {1'b0, ~(a | b)};
            3'd4:    return {1'b0, ~a};
            3'd5:    return {1'b0, a ^ b};
            3'd6:    return {1'b0, ~(a ^ b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    task automatic scramble_operands();
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    endtask

    // Starts in IDLE one tick after an edge; at least one valid must be set.
    task automatic run_txn(input logic v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                           input int unsigned hold);
        logic       win;
        logic [8:0] exp;
        win = (v0 && v1) ? ~m_last_grant : v1;
        exp = win ? ref_gate(op1, a1, b1) : ref_gate(op0, a0, b0);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = (hold == 0);
        #1;
        check("idle_ready0", req0_ready, v0 && !win);
        check("idle_ready1", req1_ready, win);
        step();
        scramble_operands();
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_ready0", req0_ready, 0);
        check("exec_ready1", req1_ready, 0);
        step();
        scramble_operands();
        check("resp_valid", rsp_valid, 1);
        check("resp_data", rsp_data, exp[7:0]);
        check("resp_id", rsp_id, win);
        check("resp_err", rsp_err, exp[8]);
        check("resp_done", done_cnt, m_done);
        obs_data = rsp_data;
        obs_id   = rsp_id;
        for (int i = 0; i < int'(hold); i++) begin
            step();
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, exp[7:0]);
            check("hold_id", rsp_id, win);
            check("hold_ready0", req0_ready, 0);
            check("hold_ready1", req1_ready, 0);
            check("hold_done", done_cnt, m_done);
        end
        rsp_ready = 1'b1;
        step();
        m_done       = m_done + 8'd1;
        m_last_grant = win;
        check("post_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        check("post_done", done_cnt, m_done);
        check("post_data_kept", rsp_data, exp[7:0]);
    endtask

    logic [7:0] sweep_exp [8];
    logic       alt_start;

    initial begin
        sweep_exp = '{8'h88, 8'hEE, 8'h77, 8'h11, 8'h55, 8'h66, 8'h99, 8'h00};
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        m_last_grant = 1'b1; m_done = 8'd0;
        #12;
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        check("rst_err", rsp_err, 0);
        check("rst_done", done_cnt, 0);
        rst_n = 1'b1;

        run_txn(1, 3'b000, 8'hF0, 8'h3C, 0, 3'b000, 8'h00, 8'h00, 0);
        check("basic_and", obs_data, 8'h30);

        for (int op = 0; op < 8; op++) begin
            run_txn(1, 3'(op), 8'hAA, 8'hCC, 0, 3'b000, 8'h00, 8'h00, 0);
            check("sweep_data", obs_data, sweep_exp[op]);
        end

        alt_start = ~m_last_grant;
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 3'($urandom_range(6)), 8'($urandom), 8'($urandom),
                    1, 3'($urandom_range(6)), 8'($urandom), 8'($urandom), 0);
            check("alt_id", obs_id, alt_start ^ 1'(i));
        end

        run_txn(1, 3'b101, 8'h5A, 8'h0F, 1, 3'b001, 8'h12, 8'h34, 5);

        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("drop_ready_on", req0_ready, 1);
        req0_valid = 1'b0;
        #1;
        check("drop_ready_off", req0_ready, 0);
        step();
        check("drop_busy", busy, 0);
        check("drop_done", done_cnt, m_done);

        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h0F; req0_b = 8'hF0;
        step();
        req0_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_done", done_cnt, 0);
        check("mid_rst_busy", busy, 0);
        m_done = 8'd0; m_last_grant = 1'b1;
        step();
        rst_n = 1'b1;
        run_txn(0, 3'b000, 8'h00, 8'h00, 1, 3'b110, 8'h3C, 8'hA5, 0);

        for (int i = 0; i < 255; i++) begin
            logic v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            run_txn(v0, 3'($urandom), 8'($urandom), 8'($urandom),
                    v1, 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(2));
        end
        check("wrap_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
